// File: rtl/br_flow_dispatch_fixed_pkg.sv
// ============================================================================
// br_flow_dispatch_fixed_pkg : shared limits for the fixed-priority dispatcher
// Rev 1.0
// ============================================================================
`default_nettype none

package br_flow_dispatch_fixed_pkg;
    localparam int c_MIN_NUM_FLOWS = 2;
    localparam int c_MIN_WIDTH     = 1;
endpackage

`default_nettype wire

// File: rtl/br_enc_priority_encoder.sv
// ============================================================================
// br_enc_priority_encoder : one-hot of the lowest set request bit (0 if none)
// Rev 1.0
// ============================================================================
`default_nettype none

module br_enc_priority_encoder #(
    parameter int NumRequesters = 2
) (
    input  logic [NumRequesters-1:0] i_req,
    output logic [NumRequesters-1:0] o_grant
);
    // Two's-complement isolation of the least significant set bit.
    assign o_grant = i_req & (~i_req + NumRequesters'(1));
endmodule

`default_nettype wire

// File: rtl/br_flow_dispatch_slot.sv
// ============================================================================
// br_flow_dispatch_slot : 1-entry valid/data staging register
// Rev 1.0
// ============================================================================
`default_nettype none

module br_flow_dispatch_slot #(
    parameter int Width = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_unload,
    input  logic [Width-1:0] i_data,
    output logic             o_valid,
    output logic [Width-1:0] o_data
);
    logic             r_full;
    logic [Width-1:0] r_data;

    // Load and unload never coincide: only empty slots are ever granted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_full;
    assign o_data  = r_data;
endmodule

`default_nettype wire

// File: rtl/br_flow_dispatch_fixed.sv
// ============================================================================
// br_flow_dispatch_fixed : one producer to NumFlows consumers, lowest free slot
// Rev 1.0
// ============================================================================
`default_nettype none

module br_flow_dispatch_fixed
    import br_flow_dispatch_fixed_pkg::*;
#(
    parameter int NumFlows                       = 2,
    parameter int Width                          = 1,
    parameter bit EnableAssertPushValidStability = 1,
    parameter bit EnableCoverPopBackpressure     = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic                           push_ready,
    input  logic                           push_valid,
    input  logic [Width-1:0]               push_data,
    input  logic [NumFlows-1:0]            pop_ready,
    output logic [NumFlows-1:0]            pop_valid,
    output logic [NumFlows-1:0][Width-1:0] pop_data
);
    logic [NumFlows-1:0] w_slot_full;
    logic [NumFlows-1:0] w_free;
    logic [NumFlows-1:0] w_grant;
    logic                w_push;

    // pop_ready is deliberately kept out of w_free so push_ready never
    // depends combinationally on the consumers.
    assign w_free     = ~w_slot_full;
    assign push_ready = (|w_free) && rst_n;
    assign w_push     = push_valid && push_ready;

    br_enc_priority_encoder #(
        .NumRequesters(NumFlows)
    ) u_enc (
        .i_req  (w_free),
        .o_grant(w_grant)
    );

    generate
        for (genvar i = 0; i < NumFlows; i++) begin : g_slot
            br_flow_dispatch_slot #(
                .Width(Width)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_load  (w_push && w_grant[i]),
                .i_unload(w_slot_full[i] && pop_ready[i]),
                .i_data  (push_data),
                .o_valid (w_slot_full[i]),
                .o_data  (pop_data[i])
            );
        end
    endgenerate

    assign pop_valid = w_slot_full;

`ifndef SYNTHESIS
    a_num_flows: assert property (@(posedge clk) NumFlows >= c_MIN_NUM_FLOWS);
    a_width:     assert property (@(posedge clk) Width >= c_MIN_WIDTH);

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(w_grant));
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        (&w_slot_full) |-> !w_push);

    generate
        for (genvar j = 1; j < NumFlows; j++) begin : g_prio_chk
            a_strict_prio: assert property (@(posedge clk) disable iff (!rst_n)
                w_grant[j] |-> &w_slot_full[j-1:0]);
        end
        for (genvar k = 0; k < NumFlows; k++) begin : g_pop_chk
            a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
                pop_valid[k] && !pop_ready[k] |=> pop_valid[k] && $stable(pop_data[k]));
            if (EnableCoverPopBackpressure) begin : g_cov
                c_pop_bp: cover property (@(posedge clk) disable iff (!rst_n)
                    pop_valid[k] && !pop_ready[k]);
            end
        end
        if (EnableAssertPushValidStability) begin : g_push_stab
            a_push_stable: assert property (@(posedge clk) disable iff (!rst_n)
                push_valid && !push_ready |=> push_valid && $stable(push_data));
        end
    endgenerate
`endif
endmodule

`default_nettype wire

// File: tb/tb_br_flow_dispatch_fixed.sv
// ============================================================================
// tb_br_flow_dispatch_fixed : scoreboard bench for the 4-output dispatcher
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_br_flow_dispatch_fixed;
    localparam int N = 4;
    localparam int W = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               push_ready;
    logic               push_valid;
    logic [W-1:0]       push_data;
    logic [N-1:0]       pop_ready;
    logic [N-1:0]       pop_valid;
    logic [N-1:0][W-1:0] pop_data;

    int total = 0;
    int bad   = 0;

    logic [N-1:0] m_full;
    logic [W-1:0] exp_q [N][$];

    br_flow_dispatch_fixed #(
        .NumFlows(N),
        .Width(W),
        .EnableAssertPushValidStability(1),
        .EnableCoverPopBackpressure(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_ready(push_ready),
        .push_valid(push_valid),
        .push_data (push_data),
        .pop_ready (pop_ready),
        .pop_valid (pop_valid),
        .pop_data  (pop_data)
    );

    always #5 clk = ~clk;

    // Checks outputs against the model, books pushes/pops, advances one cycle.
    task automatic step();
        logic [N-1:0] pops;
        logic [N-1:0] load;
        logic         exp_pr;
        int           g;
        #1;
        pops   = '0;
        load   = '0;
        exp_pr = rst_n && (m_full != '1);
        total++;
        if (push_ready !== exp_pr) begin
            bad++;
            $display("FAIL push_ready: got %b want %b at %0t", push_ready, exp_pr, $time);
        end
        total++;
        if (pop_valid !== m_full) begin
            bad++;
            $display("FAIL pop_valid: got %b want %b at %0t", pop_valid, m_full, $time);
        end
        for (int i = 0; i < N; i++) begin
            if (m_full[i] && exp_q[i].size() > 0) begin
                total++;
                if (pop_data[i] !== exp_q[i][0]) begin
                    bad++;
                    $display("FAIL pop_data[%0d]: got %h want %h at %0t", i, pop_data[i], exp_q[i][0], $time);
                end
                if (pop_ready[i]) begin
                    pops[i] = 1'b1;
                    void'(exp_q[i].pop_front());
                end
            end
        end
        if (push_valid && exp_pr) begin
            g = -1;
            for (int i = 0; i < N; i++) begin
                if (!m_full[i] && g < 0) g = i;
            end
            load[g] = 1'b1;
            exp_q[g].push_back(push_data);
        end
        @(posedge clk);
        if (!rst_n) begin
            m_full = '0;
            for (int i = 0; i < N; i++) exp_q[i].delete();
        end else begin
            m_full = (m_full & ~pops) | load;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = '0;
        m_full     = '0;
        @(posedge clk);
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        #1;
        total++;
        if (push_ready !== 1'b1 || pop_valid !== 4'b0000) begin
            bad++;
            $display("FAIL reset_exit: got pr=%b pv=%b want pr=1 pv=0000", push_ready, pop_valid);
        end
    endtask

    task automatic test_fill();
        pop_ready = '0;
        for (int k = 0; k < N; k++) begin
            push_valid = 1'b1;
            push_data  = 8'hA0 + W'(k);
            step();
        end
        push_valid = 1'b0;
        total++;
        if (pop_valid !== 4'b1111 || push_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full: got pv=%b pr=%b want pv=1111 pr=0", pop_valid, push_ready);
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (pop_data[k] !== 8'hA0 + W'(k)) begin
                bad++;
                $display("FAIL fill_order[%0d]: got %h want %h", k, pop_data[k], 8'hA0 + W'(k));
            end
        end
        step();
    endtask

    task automatic test_single_pop();
        pop_ready = 4'b0100;
        step();
        pop_ready = '0;
        total++;
        if (push_ready !== 1'b1 || pop_valid !== 4'b1011) begin
            bad++;
            $display("FAIL single_pop: got pr=%b pv=%b want pr=1 pv=1011", push_ready, pop_valid);
        end
        push_valid = 1'b1;
        push_data  = 8'hEE;
        step();
        push_valid = 1'b0;
        total++;
        if (pop_valid !== 4'b1111 || pop_data[2] !== 8'hEE) begin
            bad++;
            $display("FAIL refill_slot2: got pv=%b d2=%h want pv=1111 d2=ee", pop_valid, pop_data[2]);
        end
        step();
    endtask

    task automatic test_stream();
        logic [N-1:0] want;
        pop_ready = 4'b1111;
        step();
        for (int k = 0; k < 10; k++) begin
            push_valid = 1'b1;
            push_data  = W'(k);
            step();
            want = (k % 2 == 0) ? 4'b0001 : 4'b0010;
            total++;
            if (pop_valid !== want || push_ready !== 1'b1) begin
                bad++;
                $display("FAIL stream[%0d]: got pv=%b pr=%b want pv=%b pr=1", k, pop_valid, push_ready, want);
            end
        end
        push_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_hold();
        logic [N-1:0] want;
        pop_ready  = 4'b1110;
        push_valid = 1'b1;
        push_data  = 8'h55;
        step();
        for (int c = 0; c < 5; c++) begin
            push_valid = (c % 2 == 0);
            push_data  = 8'h60 + W'(c);
            step();
            want = (c % 2 == 0) ? 4'b0011 : 4'b0001;
            total++;
            if (pop_valid !== want || pop_data[0] !== 8'h55) begin
                bad++;
                $display("FAIL hold[%0d]: got pv=%b d0=%h want pv=%b d0=55", c, pop_valid, pop_data[0], want);
            end
        end
        push_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        pop_ready  = '0;
        push_valid = 1'b1;
        push_data  = 8'h77;
        step();
        push_valid = 1'b0;
        total++;
        if (pop_valid !== 4'b0011) begin
            bad++;
            $display("FAIL pre_reset: got pv=%b want 0011", pop_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        total++;
        if (pop_valid !== 4'b0000 || push_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: got pv=%b pr=%b want pv=0000 pr=1", pop_valid, push_ready);
        end
        pop_ready = 4'b1111;
        step();
        step();
        total++;
        if (pop_valid !== 4'b0000) begin
            bad++;
            $display("FAIL stale_data: got pv=%b want 0000", pop_valid);
        end
    endtask

    task automatic test_push_pop_same();
        pop_ready  = '0;
        push_valid = 1'b1;
        push_data  = 8'h81;
        step();
        pop_ready  = 4'b0001;
        push_data  = 8'h82;
        step();
        pop_ready  = '0;
        push_valid = 1'b0;
        total++;
        if (pop_valid !== 4'b0010 || pop_data[1] !== 8'h82) begin
            bad++;
            $display("FAIL push_pop_same: got pv=%b d1=%h want pv=0010 d1=82", pop_valid, pop_data[1]);
        end
        push_valid = 1'b1;
        push_data  = 8'h83;
        step();
        push_valid = 1'b0;
        total++;
        if (pop_valid !== 4'b0011 || pop_data[0] !== 8'h83) begin
            bad++;
            $display("FAIL regrant_slot0: got pv=%b d0=%h want pv=0011 d0=83", pop_valid, pop_data[0]);
        end
        pop_ready = 4'b1111;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single_pop();
        test_stream();
        test_hold();
        test_reset_mid();
        test_push_pop_same();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
